// File: rtl/pwm_duty_generator_if.sv
// rtl/pwm_duty_generator_if.sv - sample handshake bundle between the sine LUT stage and the PWM generator
interface pwm_duty_generator_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     sample_req;

    // Upstream side: offers samples, sees ready and the per-period request pulse
    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  sample_req
    );

    // PWM generator side
    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output sample_req
    );
endinterface

// File: rtl/pwm_duty_generator.sv
// rtl/pwm_duty_generator.sv - double-buffered fixed-period PWM from signed duty samples; PWM_DEADTIME_EN adds pwm_out_n with dead-time
module pwm_duty_generator #(
    parameter int DATA_W = 16,
    parameter int PERIOD = 1024,
    parameter int CNT_W  = 10,
    parameter int DEAD   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    pwm_duty_generator_if.slave  sif,
    output logic                 period_start,
    output logic                 pwm_out,
`ifdef PWM_DEADTIME_EN
    output logic                 pwm_out_n,
`endif
    output logic                 underrun
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam int                PROD_W   = DATA_W + CNT_W;
    localparam logic [PROD_W-1:0] PERIOD_P = PROD_W'(PERIOD);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  MID      = CNT_W'(PERIOD / 2);
    localparam logic [CNT_W-1:0]  DEAD_C   = CNT_W'(DEAD);

    // Reject parameter sets the counter or dead-time logic cannot represent
    if (PERIOD < 4 || (2 ** CNT_W) < PERIOD || 2 * DEAD >= PERIOD) begin : g_param_check
        $error("pwm_duty_generator: illegal PERIOD/CNT_W/DEAD combination");
    end

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   compare;
    logic [CNT_W-1:0]   shadow;
    logic [DATA_W-1:0]  stage1;
    logic               stage1_valid;
    logic               shadow_full;
    logic               pwm_raw;

    logic               take;
    logic               entry;
    logic               boundary;
    logic               load;
    logic               raw_next;
    logic [DATA_W-1:0]  offset;

    // Flipping the sign bit turns Q1.15 into offset binary (sample + 2^(DATA_W-1))
    assign offset           = {~stage1[DATA_W-1], stage1[DATA_W-2:0]};
    assign sif.sample_ready = ~stage1_valid & ~shadow_full;
    assign take             = sif.sample_valid & sif.sample_ready;
    assign period_start     = (state != IDLE) && (counter == '0);
    assign sif.sample_req   = period_start & ~stage1_valid & ~shadow_full;
    assign entry            = (state == IDLE) && enable;
    // A STOP period that is re-enabled in its last cycle behaves like a RUN boundary
    assign boundary         = (counter == LAST) && ((state == RUN) || ((state == STOP) && enable));
    assign load             = shadow_full && (entry || boundary);
    assign raw_next         = (state != IDLE) && (counter < compare);

    // Sample pipeline, period counter, duty double-buffer and run/stop sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            compare      <= MID;
            shadow       <= MID;
            stage1       <= '0;
            stage1_valid <= 1'b0;
            shadow_full  <= 1'b0;
            pwm_raw      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            stage1_valid <= take;
            if (take) begin
                stage1 <= sif.sample_in;
            end

            // stage1 and a full shadow never coexist, since ready needs both empty
            if (stage1_valid) begin
                shadow      <= CNT_W'(({{CNT_W{1'b0}}, offset} * PERIOD_P) >> DATA_W);
                shadow_full <= 1'b1;
            end else if (load) begin
                shadow_full <= 1'b0;
            end

            if (load) begin
                compare <= shadow;
            end

            if (entry) begin
                underrun <= 1'b0;
            end else if (boundary && !shadow_full) begin
                underrun <= 1'b1;
            end

            pwm_raw <= raw_next;

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    counter <= (counter == LAST) ? '0 : counter + 1'b1;
                    if (!enable) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    counter <= (counter == LAST) ? '0 : counter + 1'b1;
                    if (enable) begin
                        state <= RUN;
                    end else if (counter == LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

`ifdef PWM_DEADTIME_EN
    logic             active_q;
    logic [CNT_W-1:0] dt_cnt;

    // Count how long {active, raw} has held its level; restart on every change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            dt_cnt   <= '0;
        end else begin
            active_q <= (state != IDLE);
            if ({(state != IDLE), raw_next} != {active_q, pwm_raw}) begin
                dt_cnt <= '0;
            end else if (dt_cnt < DEAD_C) begin
                dt_cnt <= dt_cnt + 1'b1;
            end
        end
    end

    // A side turns on only once its level has been stable for DEAD cycles
    assign pwm_out   = pwm_raw & (dt_cnt >= DEAD_C);
    assign pwm_out_n = active_q & ~pwm_raw & (dt_cnt >= DEAD_C);
`else
    assign pwm_out = pwm_raw;
`endif

endmodule
